// File: rtl/servo_angle_ramp.sv
// Servo command stage: accepts angle commands, converts them to pulse-width
// counts and slews the duty output toward the target by at most STEP per frame.
module servo_angle_ramp #(
  parameter int FRAME       = 2000000,
  parameter int MIN_W       = 50000,
  parameter int SCALE       = 1111,
  parameter int STEP        = 5000,
  parameter int RESET_ANGLE = 90
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_angle,
  output logic        cmd_ready,
  output logic [31:0] duty,
  output logic        frame_tick,
  output logic        busy
);

  localparam logic [31:0] FRAME_LAST = 32'(FRAME - 1);
  localparam logic [31:0] FRAME_PRE  = 32'(FRAME - 2);
  localparam logic [31:0] MIN_W_U    = 32'(MIN_W);
  localparam logic [31:0] SCALE_U    = 32'(SCALE);
  localparam logic [31:0] STEP_U     = 32'(STEP);
  localparam logic [7:0]  RST_ANGLE  = 8'(RESET_ANGLE);
  localparam logic [31:0] RST_WIDTH  = MIN_W_U + 32'(RESET_ANGLE) * SCALE_U;

  typedef enum logic [1:0] {IDLE, CALC, RAMP} state_t;

  state_t      state, state_next;
  logic [31:0] cnt;
  logic [31:0] target;
  logic [7:0]  angle;
  logic        handshake;
  logic [31:0] duty_slewed;

  function automatic logic [7:0] clamp_angle(input logic [7:0] a);
    return (a > 8'd180) ? 8'd180 : a;
  endfunction

  function automatic logic [31:0] angle_to_width(input logic [7:0] a);
    return MIN_W_U + {24'd0, a} * SCALE_U;
  endfunction

  // Magnitude is taken by comparison first so the subtraction never wraps.
  function automatic logic [31:0] slew(input logic [31:0] cur, input logic [31:0] tgt);
    if (tgt >= cur) begin
      return ((tgt - cur) <= STEP_U) ? tgt : cur + STEP_U;
    end else begin
      return ((cur - tgt) <= STEP_U) ? tgt : cur - STEP_U;
    end
  endfunction

  assign cmd_ready   = (state != CALC);
  assign busy        = (state != IDLE);
  assign handshake   = cmd_valid & cmd_ready;
  assign duty_slewed = slew(duty, target);

  // frame_tick is registered one count early so it is high while cnt == FRAME-1
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= (cnt == FRAME_LAST) ? '0 : cnt + 32'd1;
      frame_tick <= (cnt == FRAME_PRE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (handshake) state_next = CALC;
      CALC: state_next = RAMP;
      RAMP: begin
        if (handshake)                                 state_next = CALC;
        else if (frame_tick && duty_slewed == target)  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      duty   <= RST_WIDTH;
      target <= RST_WIDTH;
      angle  <= RST_ANGLE;
    end else begin
      if (handshake)                     angle  <= clamp_angle(cmd_angle);
      if (state == CALC)                 target <= angle_to_width(angle);
      if (state == RAMP && frame_tick)   duty   <= duty_slewed;
    end
  end

endmodule
